// File: rtl/fft_bram_pkg.sv
// fft_bram_pkg: shared widths, depth and capture state encoding for the FFT capture BRAM path
package fft_bram_pkg;
  localparam int FFT_DATA_W = 40;
  localparam int FFT_ADDR_W = 13;
  localparam int FFT_DEPTH  = 8192;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } cap_state_e;
endpackage

// File: rtl/bram_wr_port_reg.sv
// bram_wr_port_reg: registered BRAM port A write interface; address/data hold between writes
module bram_wr_port_reg #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o
);
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= wr_i;
      if (wr_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  assign ena_o   = wr_q;
  assign wea_o   = wr_q;
  assign addra_o = addr_q;
  assign dina_o  = data_q;
endmodule

// File: rtl/fft_bram_capture_writer.sv
// fft_bram_capture_writer: arms on a pulse, optionally aligns to SOF, writes DEPTH samples to BRAM port A
module fft_bram_capture_writer
  import fft_bram_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int ADDR_W    = FFT_ADDR_W,
  parameter int DEPTH     = FFT_DEPTH,
  parameter int ALIGN_SOF = 1
) (
  input  logic              clka_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              s_valid_i,
  input  logic              s_sof_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              sof_err_o
);
  localparam int CW    = ADDR_W + 1;
  localparam bit ALIGN = ALIGN_SOF != 0;
  cap_state_e        st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sof_err_q, sof_err_d, busy_q, done_q;
  logic              last_w, acc_new, acc_run, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  // the final word of a capture is written even when a coincident arm restarts the capture
  assign last_w  = st_q == CAPTURE && s_valid_i && cnt_q == CW'(DEPTH - 1);
  assign acc_new = arm_i && !ALIGN && s_valid_i && !last_w;
  assign acc_run = !arm_i && s_valid_i && (st_q == CAPTURE || (st_q == WAIT_SOF && s_sof_i));
  assign wr_en   = last_w || acc_new || acc_run;
  assign wr_addr = acc_new ? '0 : cnt_q[ADDR_W-1:0];
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    sof_err_d = sof_err_q;
    if (arm_i) begin
      st_d      = ALIGN ? WAIT_SOF : CAPTURE;
      cnt_d     = acc_new ? CW'(1) : '0;
      sof_err_d = 1'b0;
    end else if (st_q == WAIT_SOF && s_valid_i && s_sof_i) begin
      st_d  = CAPTURE;
      cnt_d = CW'(1);
    end else if (st_q == CAPTURE && s_valid_i) begin
      st_d      = last_w ? DONE : CAPTURE;
      cnt_d     = cnt_q + CW'(1);
      sof_err_d = sof_err_q | s_sof_i;
    end
  end
  always_ff @(posedge clka_i)
    if (rst_i) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      sof_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      sof_err_q <= sof_err_d;
      busy_q    <= st_d == WAIT_SOF || st_d == CAPTURE;
      done_q    <= st_d == DONE;
    end
  bram_wr_port_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
    .clk_i  (clka_i),
    .rst_i  (rst_i),
    .wr_i   (wr_en),
    .addr_i (wr_addr),
    .data_i (s_data_i),
    .ena_o  (ena_o),
    .wea_o  (wea_o),
    .addra_o(addra_o),
    .dina_o (dina_o)
  );
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_count_o = cnt_q;
  assign sof_err_o  = sof_err_q;
endmodule

// File: tb/tb_fft_bram_capture_writer.sv
// tb_fft_bram_capture_writer: random-stimulus bench with a transaction-level capture model and BRAM array
module tb_fft_bram_capture_writer;
  localparam int DW = 40;
  localparam int AW = 4;
  localparam int D  = 16;
  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, sv = 1'b0, ssof = 1'b0;
  logic [DW-1:0] sd = '0;
  logic ena, wea, busy, done, sof_err;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [AW:0] wr_count;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fft_bram_capture_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .ALIGN_SOF(1)) dut (
    .clka_i(clk), .rst_i(rst), .arm_i(arm), .s_valid_i(sv), .s_sof_i(ssof), .s_data_i(sd),
    .ena_o(ena), .wea_o(wea), .addra_o(addra), .dina_o(dina),
    .busy_o(busy), .done_o(done), .wr_count_o(wr_count), .sof_err_o(sof_err)
  );
  logic [AW+DW-1:0] dut_log[$], exp_log[$];
  logic [DW-1:0] bram[D];
  always @(negedge clk)
    if (ena && wea) begin
      dut_log.push_back({addra, dina});
      bram[addra] = dina;
    end
  // reference: a capture is the ordered list of accepted samples; address is list position
  bit m_wait, m_cap, m_done, m_err;
  logic [DW-1:0] m_words[$];
  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction
  function automatic bit logs_match();
    if (dut_log.size() != exp_log.size()) return 1'b0;
    foreach (exp_log[i]) if (dut_log[i] !== exp_log[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit mem_match();
    if (m_words.size() != D) return 1'b0;
    foreach (m_words[i]) if (bram[i] !== m_words[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_clear();
    m_wait = 0; m_cap = 0; m_done = 0; m_err = 0;
    m_words.delete();
  endtask
  task automatic cyc(input bit a, input bit v, input bit sof, input logic [DW-1:0] d);
    arm = a; sv = v; ssof = sof; sd = d;
    if (a) begin
      if (m_cap && v && m_words.size() == D - 1) exp_log.push_back({AW'(D - 1), d});
      model_clear();
      m_wait = 1;
    end else if (m_wait && v && sof) begin
      m_wait = 0; m_cap = 1;
      exp_log.push_back({AW'(0), d});
      m_words.push_back(d);
    end else if (m_cap && v) begin
      exp_log.push_back({AW'(m_words.size()), d});
      m_words.push_back(d);
      if (sof) m_err = 1;
      if (m_words.size() == D) begin m_cap = 0; m_done = 1; end
    end
    @(posedge clk); #1;
    arm = 0; sv = 0; ssof = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, $urandom_range(0, 1), rnd());
  endtask
  task automatic start_test();
    idle(1);
    dut_log.delete();
    exp_log.delete();
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_clear();
    n_tests++;
    if ({ena, wea, addra, dina, busy, done, wr_count, sof_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ena=%b wea=%b addra=%0d dina=%h busy=%b done=%b cnt=%0d err=%b, want all 0",
               ena, wea, addra, dina, busy, done, wr_count, sof_err);
    end
    start_test();
    for (int i = 0; i < 10; i++) cyc(0, 1, $urandom_range(0, 1), rnd());
    idle(1);
    n_tests++;
    if (dut_log.size() !== 0) begin
      n_fail++;
      $display("FAIL no_arm_writes: got %0d writes, want 0", dut_log.size());
    end
  endtask
  task automatic test_align();
    start_test();
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, rnd());
    cyc(0, 1, 1, 40'h0000100002);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, rnd());
    idle(1);
    n_tests++;
    if (dut_log.size() == 0 || dut_log[0] !== {4'd0, 40'h0000100002}) begin
      n_fail++;
      $display("FAIL align_first: got %h, want %h", dut_log.size() ? dut_log[0] : '0, {4'd0, 40'h0000100002});
    end
    n_tests++;
    if (dut_log.size() != D || dut_log[D-1][AW+DW-1:DW] !== AW'(D - 1)) begin
      n_fail++;
      $display("FAIL align_last: got %0d writes, want %0d ending at addr %0d", dut_log.size(), D, D - 1);
    end
    n_tests++;
    if ({done, busy, wr_count} !== {1'b1, 1'b0, 5'd16}) begin
      n_fail++;
      $display("FAIL align_status: got done=%b busy=%b cnt=%0d, want done=1 busy=0 cnt=16", done, busy, wr_count);
    end
    n_tests++;
    if (!mem_match()) begin
      n_fail++;
      $display("FAIL align_mem: got bram[0]=%h bram[15]=%h, want %h %h", bram[0], bram[D-1], m_words[0], m_words[$]);
    end
  endtask
  task automatic test_gapped();
    start_test();
    cyc(1, 0, 0, rnd());
    cyc(0, 1, 0, rnd());
    for (int i = 0; i < D; i++) begin
      cyc(0, 1, i == 0, rnd());
      n_tests++;
      if (done !== (i == D - 1)) begin
        n_fail++;
        $display("FAIL gapped_done@%0d: got %b, want %b", i, done, i == D - 1);
      end
      if (i < D - 1) idle($urandom_range(1, 2));
    end
    idle(1);
    n_tests++;
    if (!logs_match()) begin
      n_fail++;
      $display("FAIL gapped_writes: got %0d writes, want %0d in address order", dut_log.size(), exp_log.size());
    end
    n_tests++;
    if (!mem_match()) begin
      n_fail++;
      $display("FAIL gapped_mem: got bram[5]=%h, want %h", bram[5], m_words[5]);
    end
  endtask
  task automatic test_sof_err();
    start_test();
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < D; i++) begin
      cyc(0, 1, i == 0 || i == 6, rnd());
      if (i == 5 || i == 6) begin
        n_tests++;
        if (sof_err !== (i == 6)) begin
          n_fail++;
          $display("FAIL sof_err@%0d: got %b, want %b", i, sof_err, i == 6);
        end
      end
    end
    idle(1);
    n_tests++;
    if (!logs_match() || {done, sof_err} !== {1'b1, m_err}) begin
      n_fail++;
      $display("FAIL sof_err_capture: got %0d writes done=%b err=%b, want %0d done=1 err=1", dut_log.size(), done, sof_err, exp_log.size());
    end
    cyc(1, 0, 0, rnd());
    n_tests++;
    if ({sof_err, done, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL rearm_clear: got err=%b done=%b busy=%b, want 0 0 1", sof_err, done, busy);
    end
  endtask
  task automatic test_rearm();
    start_test();
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < 9; i++) cyc(0, 1, i == 0, rnd());
    n_tests++;
    if (wr_count !== 5'(m_words.size())) begin
      n_fail++;
      $display("FAIL rearm_mid_count: got %0d, want %0d", wr_count, m_words.size());
    end
    cyc(1, 1, 1, rnd());
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, rnd());
    for (int i = 0; i < D; i++) cyc(0, 1, i == 0, rnd());
    idle(1);
    n_tests++;
    if (!logs_match() || wr_count !== 5'd16 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_restart: got %0d writes cnt=%0d done=%b, want %0d cnt=16 done=1", dut_log.size(), wr_count, done, exp_log.size());
    end
    n_tests++;
    if (!mem_match()) begin
      n_fail++;
      $display("FAIL rearm_mem: got bram[0]=%h, want %h", bram[0], m_words[0]);
    end
  endtask
  task automatic test_arm_final();
    start_test();
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < D - 1; i++) cyc(0, 1, i == 0, rnd());
    cyc(1, 1, 0, rnd());
    n_tests++;
    if ({busy, done, wr_count} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL arm_final_state: got busy=%b done=%b cnt=%0d, want 1 0 0", busy, done, wr_count);
    end
    idle(1);
    n_tests++;
    if (!logs_match()) begin
      n_fail++;
      $display("FAIL arm_final_write: got %0d writes, want %0d incl. addr 15", dut_log.size(), exp_log.size());
    end
  endtask
  task automatic test_reset_mid();
    start_test();
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < 4; i++) cyc(0, 1, i == 0, rnd());
    n_tests++;
    if (wea !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_wea: got %b, want 1", wea);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    n_tests++;
    if ({wea, ena, busy, done, wr_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got wea=%b ena=%b busy=%b done=%b cnt=%0d, want all 0", wea, ena, busy, done, wr_count);
    end
  endtask
  initial begin
    test_reset();
    test_align();
    test_gapped();
    test_sof_err();
    test_rearm();
    test_arm_final();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
